beam_sweep_controller: RTL and testbench

- Upstream sequencer for transmit_beamformer: drives its signed beam_angle input and steps it through a ping-pong sweep, or holds a commanded angle.
- Runs the same period/burst timebase as the per-transmitter PWMs and changes the angle only at a period boundary, so offsets never move mid-burst.
- In each period's listen window, timestamps the first echo from the receive comparator and reports (angle, time-of-flight, hit) once per period.

---
 rtl/sonic_pkg.sv | 27 ++
 rtl/rise_detect.sv | 25 ++
 rtl/beam_sweep_controller.sv | 178 +++++++++++++++++
 tb/tb_beam_sweep_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// Shared types and helpers for the sonar transmit/receive chain.
//   angle_t       : signed beam angle at the default beamformer width
//   sweep_state_t : period sequencer states (IDLE, BURST, LISTEN)
//   sat_angle()   : clamps an angle into [lo, hi]
package sonic_pkg;

    localparam int ANGLE_BITS = 7;

    typedef logic signed [ANGLE_BITS-1:0] angle_t;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        LISTEN
    } sweep_state_t;

    function automatic int sat_angle(input int a, input int lo, input int hi);
        if (a < lo) begin
            return lo;
        end
        if (a > hi) begin
            return hi;
        end
        return a;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector.
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   d    : input level (already synchronous to clk)
//   rise : high in the cycle where d is 1 and was 0 in the previous cycle
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/beam_sweep_controller.sv
// Beam angle sequencer for transmit_beamformer with per-period echo timing.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   enable         : run periods while high (sampled at period boundaries)
//   hold_mode      : 1 = fixed hold_angle, 0 = ping-pong sweep
//   hold_angle     : commanded angle in hold mode (saturated to the sweep range)
//   echo_in        : receive comparator output
//   beam_angle     : angle driven to the beamformer, changes only at period start
//   burst_active   : high for the first BURST_DURATION cycles of a period
//   period_start   : pulse on the first cycle of each period
//   sweep_turn     : pulse (with period_start) when the sweep reverses
//   meas_valid     : pulse on the cycle after a period ends
//   meas_angle/tof/hit : angle, first-echo cycle index (all-ones if none), hit flag
module beam_sweep_controller
    import sonic_pkg::*;
#(
    parameter int PERIOD_DURATION = 16777216,
    parameter int BURST_DURATION  = 524288,
    parameter int ANGLE_WIDTH     = 7,
    parameter int ANGLE_MIN       = -60,
    parameter int ANGLE_MAX       = 60,
    parameter int ANGLE_STEP      = 5,
    parameter int TOF_WIDTH       = 24
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable,
    input  logic                          hold_mode,
    input  logic signed [ANGLE_WIDTH-1:0] hold_angle,
    input  logic                          echo_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle,
    output logic                          burst_active,
    output logic                          period_start,
    output logic                          sweep_turn,
    output logic                          meas_valid,
    output logic signed [ANGLE_WIDTH-1:0] meas_angle,
    output logic [TOF_WIDTH-1:0]          meas_tof,
    output logic                          meas_hit
);

    // Two guard bits so a +/- step past either endpoint cannot wrap.
    localparam int AW2 = ANGLE_WIDTH + 2;

    localparam logic [TOF_WIDTH-1:0]          CNT_LAST       = TOF_WIDTH'(PERIOD_DURATION - 1);
    localparam logic [TOF_WIDTH-1:0]          CNT_BURST_LAST = TOF_WIDTH'(BURST_DURATION - 1);
    localparam logic signed [AW2-1:0]         MIN_W          = AW2'(ANGLE_MIN);
    localparam logic signed [AW2-1:0]         MAX_W          = AW2'(ANGLE_MAX);
    localparam logic signed [AW2-1:0]         STEP_W         = AW2'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH-1:0] MIN_A          = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] MAX_A          = ANGLE_WIDTH'(ANGLE_MAX);

    sweep_state_t state, state_nxt;

    logic [TOF_WIDTH-1:0]          cnt;
    logic [TOF_WIDTH-1:0]          tof;
    logic                          hit;
    logic                          dir_up;
    logic                          rise;
    logic                          period_end;
    logic                          launch;
    logic                          eff_up;
    logic                          reach;
    logic                          dir_nxt;
    logic                          turn_nxt;
    logic signed [AW2-1:0]         a_wide;
    logic signed [AW2-1:0]         step_sum;
    logic signed [ANGLE_WIDTH-1:0] angle_nxt;
    logic signed [ANGLE_WIDTH-1:0] hold_sat;

    rise_detect u_rise (
        .clk  (clk_in),
        .rst  (rst_in),
        .d    (echo_in),
        .rise (rise)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // launch marks the edge that opens a new period (from IDLE or from the last LISTEN cycle).
    always_comb begin
        state_nxt  = state;
        period_end = (state == LISTEN) && (cnt == CNT_LAST);
        case (state)
            IDLE:    if (enable) state_nxt = BURST;
            BURST:   if (cnt == CNT_BURST_LAST) state_nxt = LISTEN;
            LISTEN:  if (period_end) state_nxt = enable ? BURST : IDLE;
            default: state_nxt = IDLE;
        endcase
        launch = (state_nxt == BURST) && (state != BURST);
    end

    // Next sweep angle. If the sweep resumes (after hold) sitting on the endpoint it is
    // heading towards, it turns around first instead of clamping in place.
    always_comb begin
        hold_sat = ANGLE_WIDTH'(sat_angle(int'(hold_angle), ANGLE_MIN, ANGLE_MAX));
        a_wide   = AW2'(beam_angle);
        eff_up   = dir_up;
        if (dir_up && (a_wide >= MAX_W)) begin
            eff_up = 1'b0;
        end else if (!dir_up && (a_wide <= MIN_W)) begin
            eff_up = 1'b1;
        end
        step_sum = eff_up ? (a_wide + STEP_W) : (a_wide - STEP_W);
        reach    = eff_up ? (step_sum >= MAX_W) : (step_sum <= MIN_W);
        if (reach) begin
            angle_nxt = eff_up ? MAX_A : MIN_A;
        end else begin
            angle_nxt = step_sum[ANGLE_WIDTH-1:0];
        end
        dir_nxt  = reach ? ~eff_up : eff_up;
        turn_nxt = reach | (eff_up != dir_up);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt          <= '0;
            tof          <= '1;
            hit          <= 1'b0;
            dir_up       <= 1'b1;
            beam_angle   <= '0;
            burst_active <= 1'b0;
            period_start <= 1'b0;
            sweep_turn   <= 1'b0;
            meas_valid   <= 1'b0;
            meas_angle   <= '0;
            meas_tof     <= '0;
            meas_hit     <= 1'b0;
        end else begin
            period_start <= launch;
            sweep_turn   <= 1'b0;
            meas_valid   <= period_end;
            burst_active <= (state_nxt == BURST);

            if (launch || (state_nxt == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // An edge on the final cycle is folded straight into the report.
            if (period_end) begin
                meas_angle <= beam_angle;
                meas_hit   <= hit | rise;
                if (hit) begin
                    meas_tof <= tof;
                end else if (rise) begin
                    meas_tof <= cnt;
                end else begin
                    meas_tof <= '1;
                end
                hit <= 1'b0;
                tof <= '1;
            end else if ((state == LISTEN) && rise && !hit) begin
                hit <= 1'b1;
                tof <= cnt;
            end

            if (launch) begin
                if (hold_mode) begin
                    beam_angle <= hold_sat;
                end else if (state == IDLE) begin
                    beam_angle <= MIN_A;
                    dir_up     <= 1'b1;
                end else begin
                    beam_angle <= angle_nxt;
                    dir_up     <= dir_nxt;
                    sweep_turn <= turn_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Directed bench for beam_sweep_controller with a small period (100 cycles, 10-cycle burst).
module tb_beam_sweep_controller;

    localparam int PD   = 100;
    localparam int BD   = 10;
    localparam int AW   = 7;
    localparam int AMIN = -10;
    localparam int AMAX = 10;
    localparam int AST  = 6;
    localparam int TW   = 8;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 enable;
    logic                 hold_mode;
    logic signed [AW-1:0] hold_angle;
    logic                 echo_in;
    logic signed [AW-1:0] beam_angle;
    logic                 burst_active;
    logic                 period_start;
    logic                 sweep_turn;
    logic                 meas_valid;
    logic signed [AW-1:0] meas_angle;
    logic [TW-1:0]        meas_tof;
    logic                 meas_hit;

    beam_sweep_controller #(
        .PERIOD_DURATION (PD),
        .BURST_DURATION  (BD),
        .ANGLE_WIDTH     (AW),
        .ANGLE_MIN       (AMIN),
        .ANGLE_MAX       (AMAX),
        .ANGLE_STEP      (AST),
        .TOF_WIDTH       (TW)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .enable       (enable),
        .hold_mode    (hold_mode),
        .hold_angle   (hold_angle),
        .echo_in      (echo_in),
        .beam_angle   (beam_angle),
        .burst_active (burst_active),
        .period_start (period_start),
        .sweep_turn   (sweep_turn),
        .meas_valid   (meas_valid),
        .meas_angle   (meas_angle),
        .meas_tof     (meas_tof),
        .meas_hit     (meas_hit)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Per-period record: expected angle/turn on entry, echo pulses (start cnt, length), expected report.
    typedef struct {
        int angle;
        int turn;
        int r1;
        int l1;
        int r2;
        int l2;
        int tof;
        int hit;
    } per_vec_t;

    per_vec_t vec[11];

    function automatic logic echo_at(input per_vec_t v, input int c);
        return ((c >= v.r1) && (c < v.r1 + v.l1)) || ((c >= v.r2) && (c < v.r2 + v.l2));
    endfunction

    initial begin
        vec[0]  = '{-10, 0,  5,  3, 40, 3,  40, 1};  // burst edge ignored, first listen edge
        vec[1]  = '{ -4, 0, 37,  3, 60, 3,  37, 1};  // second listen edge ignored
        vec[2]  = '{  2, 0,  0,  0,  0, 0, 255, 0};  // no echo
        vec[3]  = '{  8, 0, 99,  1,  0, 0,  99, 1};  // edge on last cycle
        vec[4]  = '{ 10, 1,  8, 25, 50, 3,  50, 1};  // high across burst end, re-rise at 50
        vec[5]  = '{  4, 0,  0,  0,  0, 0, 255, 0};
        vec[6]  = '{ -2, 0, 15,  2,  0, 0,  15, 1};
        vec[7]  = '{ -8, 0,  9,  2,  0, 0, 255, 0};  // rises in burst, still high at listen start
        vec[8]  = '{-10, 1, 10,  1,  0, 0,  10, 1};  // edge on first listen cycle
        vec[9]  = '{ -4, 0,  0,  0,  0, 0, 255, 0};
        vec[10] = '{  2, 0,  0,  0,  0, 0, 255, 0};

        rst_in     = 1'b1;
        enable     = 1'b0;
        hold_mode  = 1'b0;
        hold_angle = '0;
        echo_in    = 1'b0;
        ticks(2);
        check("reset beam_angle", int'(beam_angle), 0);
        check("reset burst_active", int'(burst_active), 0);
        check("reset period_start", int'(period_start), 0);
        check("reset meas_valid", int'(meas_valid), 0);
        check("reset meas_tof", int'(meas_tof), 0);
        rst_in = 1'b0;
        ticks(3);
        check("idle period_start", int'(period_start), 0);
        check("idle burst_active", int'(burst_active), 0);

        // Sweep over ten periods with the echo scenarios above.
        enable = 1'b1;
        tick();
        for (int p = 0; p <= 10; p++) begin
            check($sformatf("p%0d beam_angle", p), int'(beam_angle), vec[p].angle);
            check($sformatf("p%0d period_start", p), int'(period_start), 1);
            check($sformatf("p%0d sweep_turn", p), int'(sweep_turn), vec[p].turn);
            check($sformatf("p%0d meas_valid", p), int'(meas_valid), (p > 0) ? 1 : 0);
            if (p > 0) begin
                check($sformatf("p%0d meas_angle", p), int'(meas_angle), vec[p-1].angle);
                check($sformatf("p%0d meas_tof", p), int'(meas_tof), vec[p-1].tof);
                check($sformatf("p%0d meas_hit", p), int'(meas_hit), vec[p-1].hit);
            end
            if (p == 10) break;
            begin
                int bad;
                bad = 0;
                for (int c = 0; c < PD; c++) begin
                    if (burst_active != (c < BD)) bad++;
                    if (int'(beam_angle) != vec[p].angle) bad++;
                    if (c > 0) begin
                        if (period_start) bad++;
                        if (sweep_turn) bad++;
                        if (meas_valid) bad++;
                    end
                    echo_in = echo_at(vec[p], c);
                    tick();
                end
                check($sformatf("p%0d cycle shape errors", p), bad, 0);
            end
        end
        echo_in = 1'b0;

        // Hold mode: request applied mid-period lands only at the boundary, saturated.
        ticks(30);
        hold_mode  = 1'b1;
        hold_angle = 7'sd50;
        ticks(69);
        check("hold pending angle", int'(beam_angle), 2);
        tick();
        check("hold angle sat", int'(beam_angle), 10);
        check("hold sweep_turn", int'(sweep_turn), 0);
        check("hold period_start", int'(period_start), 1);
        check("no-echo meas_tof", int'(meas_tof), 255);
        check("no-echo meas_hit", int'(meas_hit), 0);
        check("hold meas_angle", int'(meas_angle), 2);
        ticks(40);
        hold_angle = -7'sd3;
        ticks(60);
        check("hold angle -3", int'(beam_angle), -3);
        ticks(40);
        hold_mode = 1'b0;
        ticks(60);
        check("resume sweep angle", int'(beam_angle), 3);
        check("resume sweep_turn", int'(sweep_turn), 0);

        // Enable dropped mid-period: period completes, report fires, then idle.
        ticks(20);
        enable = 1'b0;
        ticks(80);
        check("stop meas_valid", int'(meas_valid), 1);
        check("stop period_start", int'(period_start), 0);
        check("stop burst_active", int'(burst_active), 0);
        check("stop beam_angle held", int'(beam_angle), 3);
        check("stop meas_angle", int'(meas_angle), 3);
        ticks(5);
        check("idle meas_valid", int'(meas_valid), 0);
        check("idle beam_angle held", int'(beam_angle), 3);
        check("idle no period_start", int'(period_start), 0);

        // Restart (sweep from ANGLE_MIN), then reset mid-LISTEN.
        enable = 1'b1;
        tick();
        check("restart beam_angle", int'(beam_angle), -10);
        check("restart period_start", int'(period_start), 1);
        ticks(40);
        echo_in = 1'b1;
        ticks(3);
        echo_in = 1'b0;
        ticks(7);
        #2;
        rst_in = 1'b1;
        #1;
        check("midreset beam_angle", int'(beam_angle), 0);
        check("midreset burst_active", int'(burst_active), 0);
        check("midreset meas_angle", int'(meas_angle), 0);
        check("midreset meas_tof", int'(meas_tof), 0);
        check("midreset meas_hit", int'(meas_hit), 0);
        check("midreset meas_valid", int'(meas_valid), 0);
        enable = 1'b0;
        #1;
        rst_in = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (meas_valid || period_start || burst_active || sweep_turn) pulses++;
            end
            check("post-reset activity", pulses, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
